uart_lcd_writer: RTL

//  Downstream consumer of the UART receiver: takes each received byte (rx byte + data-ready

---
 rtl/uart_lcd_pkg.sv | 53 +++++
 rtl/byte_fifo.sv | 50 +++++
 rtl/uart_lcd_writer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_lcd_pkg.sv
// Shared definitions for the UART-to-LCD writer: HD44780 command bytes, control
// characters, FSM state encoding and small width helpers.
package uart_lcd_pkg;

  // HD44780 commands (8-bit interface)
  localparam logic [7:0] WAKE_8B     = 8'h30;
  localparam logic [7:0] FUNC_SET_8B = 8'h38;
  localparam logic [7:0] DISP_OFF    = 8'h08;
  localparam logic [7:0] CLEAR       = 8'h01;
  localparam logic [7:0] ENTRY_INC   = 8'h06;
  localparam logic [7:0] DISP_ON     = 8'h0C;
  localparam logic [7:0] SET_DDRAM   = 8'h80;
  localparam logic [7:0] LINE2_BASE  = 8'h40;

  // Control characters interpreted from the byte stream
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_FF = 8'h0C;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  localparam int unsigned INIT_LEN = 8;

  typedef enum logic [2:0] {
    StPwrup, StIdle, StDecode, StSetup, StEHigh, StHold, StExec
  } lcd_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Power-up command list; the first three wake-ups force 8-bit mode from any state
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0, 3'd1, 3'd2: c = WAKE_8B;
      3'd3:             c = FUNC_SET_8B;
      3'd4:             c = DISP_OFF;
      3'd5:             c = CLEAR;
      3'd6:             c = ENTRY_INC;
      default:          c = DISP_ON;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with show-ahead read data.
// Ports: clk/rst_n clock and async active-low reset; push/din write; pop read (dout is the
// head entry while not empty); full/empty status. Push while full is ignored, pop while
// empty is ignored, push and pop together both take effect.
module byte_fifo
  import uart_lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/uart_lcd_writer.sv
// Prints bytes received from a UART on a 16x2 HD44780 LCD (8-bit, write-only).
// Ports: clk_50M/rst_n clock and async active-low reset; rx_data/rx_dr received byte and
// its (asynchronous) data-ready level; lcd_rs/lcd_rw/lcd_e/lcd_db LCD bus; busy high unless
// idle with nothing buffered; fifo_full buffer full; overflow sticky byte-dropped flag.
module uart_lcd_writer
  import uart_lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned COLS          = 16,
  parameter int unsigned T_POWERUP_CYC = 750000,
  parameter int unsigned T_INIT1_CYC   = 205000,
  parameter int unsigned T_INIT2_CYC   = 5000,
  parameter int unsigned T_CMD_CYC     = 2000,
  parameter int unsigned T_CLR_CYC     = 82000,
  parameter int unsigned T_SETUP_CYC   = 2,
  parameter int unsigned T_EHIGH_CYC   = 25,
  parameter int unsigned T_HOLD_CYC    = 2
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_dr,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_POWERUP_CYC, T_INIT1_CYC),
      max_u(T_INIT2_CYC, T_CMD_CYC)), max_u(max_u(T_CLR_CYC, T_SETUP_CYC),
      max_u(T_EHIGH_CYC, T_HOLD_CYC)));
  localparam int unsigned CNT_W = clog2(T_MAX + 1);
  localparam int unsigned COL_W = clog2(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  function automatic logic [7:0] ddram_addr(input logic row, input logic [COL_W-1:0] col);
    logic [7:0] a;
    a = SET_DDRAM | 8'(col);
    if (row) a = a | LINE2_BASE;
    return a;
  endfunction

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, exec_q, exec_d;
  logic             init_q, init_d, addr_pend_q, addr_pend_d;
  logic [2:0]       init_idx_q, init_idx_d;
  logic             row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       byte_q, byte_d, db_q, db_d;
  logic             rs_q, rs_d, e_q, e_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q, overflow_q;
  logic             push, pop, fifo_empty, cnt_zero;
  logic [7:0]       fifo_dout;
  logic             start_wr, wr_rs;
  logic [7:0]       wr_db;

  // rx_dr comes from the slow UART domain: synchronise, then take its rising edge
  assign push = rx_sync_q & ~rx_prev_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .push  (push),
    .din   (rx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    exec_d      = exec_q;
    init_d      = init_q;
    init_idx_d  = init_idx_q;
    addr_pend_d = addr_pend_q;
    row_d       = row_q;
    col_d       = col_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    db_d        = db_q;
    pop         = 1'b0;
    start_wr    = 1'b0;
    wr_rs       = 1'b0;
    wr_db       = 8'h00;

    unique case (state_q)
      StPwrup: begin
        if (cnt_zero) begin
          start_wr = 1'b1;
          wr_db    = init_cmd(3'd0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          byte_d  = fifo_dout;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
          start_wr = 1'b1;
          wr_rs    = 1'b1;
          wr_db    = byte_q;
          // Wrap to the start of the other line; the address is set after this write
          if (col_q == COL_LAST) begin
            col_d       = '0;
            row_d       = ~row_q;
            addr_pend_d = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else if (byte_q == CHAR_CR) begin
          col_d    = '0;
          start_wr = 1'b1;
          wr_db    = ddram_addr(row_q, '0);
        end else if (byte_q == CHAR_LF) begin
          row_d    = ~row_q;
          col_d    = '0;
          start_wr = 1'b1;
          wr_db    = ddram_addr(~row_q, '0);
        end else if (byte_q == CHAR_FF) begin
          row_d    = 1'b0;
          col_d    = '0;
          start_wr = 1'b1;
          wr_db    = CLEAR;
        end else begin
          state_d = StIdle;
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          state_d = StEHigh;
          cnt_d   = CNT_W'(T_EHIGH_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StEHigh: begin
        if (cnt_zero) begin
          state_d = StHold;
          cnt_d   = CNT_W'(T_HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (cnt_zero) begin
          state_d = StExec;
          cnt_d   = exec_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StExec: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (init_q) begin
          if (init_idx_q == 3'(INIT_LEN - 1)) begin
            init_d  = 1'b0;
            state_d = StIdle;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
            start_wr   = 1'b1;
            wr_db      = init_cmd(init_idx_q + 3'd1);
          end
        end else if (addr_pend_q) begin
          addr_pend_d = 1'b0;
          start_wr    = 1'b1;
          wr_db       = ddram_addr(row_q, col_q);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StPwrup;
    endcase

    if (start_wr) begin
      state_d = StSetup;
      cnt_d   = CNT_W'(T_SETUP_CYC - 1);
      rs_d    = wr_rs;
      db_d    = wr_db;
      if (init_d && init_idx_d == 3'd0)      exec_d = CNT_W'(T_INIT1_CYC - 1);
      else if (init_d && init_idx_d == 3'd1) exec_d = CNT_W'(T_INIT2_CYC - 1);
      else if (!wr_rs && wr_db == CLEAR)     exec_d = CNT_W'(T_CLR_CYC - 1);
      else                                   exec_d = CNT_W'(T_CMD_CYC - 1);
    end
  end

  // E is registered from the next state so the strobe is glitch-free
  assign e_d = (state_d == StEHigh);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPwrup;
      cnt_q       <= CNT_W'(T_POWERUP_CYC - 1);
      exec_q      <= '0;
      init_q      <= 1'b1;
      init_idx_q  <= 3'd0;
      addr_pend_q <= 1'b0;
      row_q       <= 1'b0;
      col_q       <= '0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      db_q        <= 8'h00;
      e_q         <= 1'b0;
      rx_meta_q   <= 1'b0;
      rx_sync_q   <= 1'b0;
      rx_prev_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exec_q      <= exec_d;
      init_q      <= init_d;
      init_idx_q  <= init_idx_d;
      addr_pend_q <= addr_pend_d;
      row_q       <= row_d;
      col_q       <= col_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      db_q        <= db_d;
      e_q         <= e_d;
      rx_meta_q   <= rx_dr;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      if (push && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign lcd_db   = db_q;
  assign overflow = overflow_q;
  assign busy     = !((state_q == StIdle) && fifo_empty);

endmodule
